pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central control block for the five-stage MIPS pipeline. It sits beside instruction decode and owns the `i_stall`/`i_halt` inputs of the IF/ID stages. It sequences the pipeline through idle, free-run, single-step, drain and done states for the debug unit. It also detects load-use hazards and generates the bubble/flush controls for branches.

## Interface
- `DRAIN_CYCLES`, default 4: cycles to drain after a HALT leaves ID, so HALT reaches write-back; legal range 1..15.
- `i_clk`  in  1  system clock; all state updates on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_dbg_run`  in  1  one-cycle pulse from debug unit: start free-run
- `i_dbg_step`  in  1  one-cycle pulse from debug unit: advance pipeline exactly one cycle
- `i_id_rs`  in  5  rs address of instruction in ID
- `i_id_rt`  in  5  rt address of instruction in ID
- `i_id_halt`  in  1  instruction in ID is HALT
- `i_ex_rt`  in  5  destination rt of instruction in EX
- `i_ex_mem_read`  in  1  instruction in EX is a load
- `i_ex_branch_taken`  in  1  branch/jump resolved taken in EX
- `o_halt`  out  1  freeze all pipeline registers and PC
- `o_stall`  out  1  hold PC and IF/ID (load-use)
- `o_pc_write_en`  out  1  PC may update
- `o_flush_ifid`  out  1  load NOP into IF/ID
- `o_flush_idex`  out  1  load bubble into ID/EX
- `o_state`  out  3  current FSM state (registered)
- `o_done`  out  1  program finished (registered)
- `o_cycle_count`  out  32  count of advancing cycles (registered)

## Operation
- States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. Encodings 5..7 are unreachable and recover to IDLE.
- IDLE:
  - outputs: `o_halt`=1, `o_pc_write_en`=0.
  - transitions: `i_dbg_run` → RUN. `i_dbg_step` → STEP. If both are asserted, run wins.
- RUN: pipeline advances, `o_halt`=0.
- STEP: pipeline advances for exactly one cycle, `o_halt`=0. Next state is IDLE, or DRAIN if HALT is accepted that cycle.
- Hazard logic is combinational and applies only in RUN/STEP:
  - `lu` = `i_ex_mem_read` & (`i_ex_rt`≠0) & (`i_ex_rt`==`i_id_rs` | `i_ex_rt`==`i_id_rt`).
  - If `i_ex_branch_taken`: `o_flush_ifid`=1, `o_flush_idex`=1, `o_pc_write_en`=1, `o_stall`=0. Branch has priority over `lu`, because the ID instruction is wrong-path.
  - Else if `lu`: `o_stall`=1, `o_pc_write_en`=0, `o_flush_idex`=1.
  - Else all hazard outputs are 0 and `o_pc_write_en`=1.
- HALT acceptance happens in RUN/STEP when `i_id_halt` & !`lu` & !`i_ex_branch_taken`.
  - The next state is DRAIN.
  - The drain counter loads `DRAIN_CYCLES`-1.
  - A stalled HALT waits. A HALT in ID during a taken branch is ignored.
- DRAIN:
  - outputs: `o_halt`=0, `o_pc_write_en`=0, `o_flush_ifid`=1; no new fetch.
  - the counter decrements each cycle.
  - at 0 the next state is DONE.
  - hazard logic is disabled: `o_stall`=0, `o_flush_idex`=0.
  - debug pulses are ignored.
- DONE:
  - outputs: `o_halt`=1, `o_done`=1.
  - the block stays in DONE until reset; debug pulses are ignored.
- `o_cycle_count` increments every cycle in which `o_halt`=0, including stall and drain cycles. It wraps 0xFFFFFFFF→0 and is cleared only by reset.

## Timing
- Reset values (async): `o_state`=IDLE, `o_done`=0, `o_cycle_count`=0, drain counter 0. Combinational outputs at reset: `o_halt`=1, `o_stall`=0, `o_pc_write_en`=0, both flushes 0.
- Reset asserted mid-RUN/DRAIN forces IDLE immediately, without waiting for a clock edge.
- `o_halt`, `o_stall`, `o_pc_write_en` and the flushes are combinational from state and this cycle's inputs.
- There is no registered latency between hazard and stall; the stalling edge is the same edge that would have advanced the pipeline.
- Pulse latency:
  - a pulse sampled at edge N gives state RUN/STEP after edge N.
  - the first advancing edge is N+1.
  - STEP returns to IDLE after edge N+1.
- Drain length:
  - HALT accepted at edge H.
  - DRAIN occupies edges H+1 .. H+`DRAIN_CYCLES`.
  - `o_done`=1 after edge H+`DRAIN_CYCLES`.

## Test plan
- Reset, then one `i_dbg_step` pulse → exactly one cycle with `o_halt`=0, `o_cycle_count`=1, `o_state` back to 0.
- RUN with `i_ex_mem_read`=1, `i_ex_rt`=5, `i_id_rs`=5 → `o_stall`=1, `o_flush_idex`=1, `o_pc_write_en`=0. Repeat with `i_ex_rt`=0 → no stall.
- RUN with `lu` and `i_ex_branch_taken` both asserted → `o_flush_ifid`=1, `o_flush_idex`=1, `o_stall`=0, `o_pc_write_en`=1.
- RUN, `i_id_halt`=1 for one cycle, `DRAIN_CYCLES`=4 → 4 DRAIN cycles with `o_pc_write_en`=0, then `o_done`=1, `o_state`=4. Later `i_dbg_run` pulses are ignored.
- HALT in ID while `lu` is asserted for 1 cycle → DRAIN entered one cycle later. HALT together with a taken branch → stays in RUN.
- Assert `i_reset` mid-DRAIN, asynchronously between edges → `o_state`=0, `o_cycle_count`=0, `o_halt`=1 immediately.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline control for the five-stage MIPS core: debug run/step sequencing,
// load-use stall detection, branch flushes and the HALT drain to completion.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dbg_run,
  input  logic        i_dbg_step,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_halt,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_branch_taken,
  output logic        o_halt,
  output logic        o_stall,
  output logic        o_pc_write_en,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic [2:0]  o_state,
  output logic        o_done,
  output logic [31:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        done;
  logic [31:0] cycle_count;

  logic advancing;
  logic draining;
  logic load_use;
  logic halt_accept;

  assign advancing = (state == RUN) || (state == STEP);
  assign draining  = (state == DRAIN);

  assign load_use = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  // A stalled HALT waits for the load to clear; one on the wrong path is dropped.
  assign halt_accept = advancing && i_id_halt && !load_use && !i_ex_branch_taken;

  always_comb begin
    o_halt        = 1'b1;
    o_stall       = 1'b0;
    o_pc_write_en = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    if (advancing) begin
      o_halt = 1'b0;
      if (i_ex_branch_taken) begin
        o_flush_ifid  = 1'b1;
        o_flush_idex  = 1'b1;
        o_pc_write_en = 1'b1;
      end else if (load_use) begin
        o_stall      = 1'b1;
        o_flush_idex = 1'b1;
      end else begin
        o_pc_write_en = 1'b1;
      end
    end else if (draining) begin
      o_halt       = 1'b0;
      o_flush_ifid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      drain_cnt   <= 4'd0;
      done        <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      if (!o_halt)
        cycle_count <= cycle_count + 32'd1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (i_dbg_run)
            state <= RUN;
          else if (i_dbg_step)
            state <= STEP;
        end
        RUN: begin
          if (halt_accept) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        STEP: begin
          if (halt_accept) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          drain_cnt <= 4'd0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign o_state       = state;
  assign o_done        = done;
  assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the sequencer.
module tb_pipeline_sequencer;

  localparam int DRAIN = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_dbg_run = 1'b0;
  logic        i_dbg_step = 1'b0;
  logic [4:0]  i_id_rs = 5'd0;
  logic [4:0]  i_id_rt = 5'd0;
  logic        i_id_halt = 1'b0;
  logic [4:0]  i_ex_rt = 5'd0;
  logic        i_ex_mem_read = 1'b0;
  logic        i_ex_branch_taken = 1'b0;
  logic        o_halt;
  logic        o_stall;
  logic        o_pc_write_en;
  logic        o_flush_ifid;
  logic        o_flush_idex;
  logic [2:0]  o_state;
  logic        o_done;
  logic [31:0] o_cycle_count;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_dbg_run(i_dbg_run),
    .i_dbg_step(i_dbg_step),
    .i_id_rs(i_id_rs),
    .i_id_rt(i_id_rt),
    .i_id_halt(i_id_halt),
    .i_ex_rt(i_ex_rt),
    .i_ex_mem_read(i_ex_mem_read),
    .i_ex_branch_taken(i_ex_branch_taken),
    .o_halt(o_halt),
    .o_stall(o_stall),
    .o_pc_write_en(o_pc_write_en),
    .o_flush_ifid(o_flush_ifid),
    .o_flush_idex(o_flush_idex),
    .o_state(o_state),
    .o_done(o_done),
    .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  int checkCount = 0;
  int errorCount = 0;

  // Model: mode uses the published state numbering, drainLeft counts the
  // drain cycles still to go, count mirrors the advancing-cycle counter.
  int          mMode = 0;
  int          mDrainLeft = 0;
  logic [31:0] mCount = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic halt,
                               input logic memRead, input logic branch,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] exRt);
    i_dbg_run         = run;
    i_dbg_step        = step;
    i_id_halt         = halt;
    i_ex_mem_read     = memRead;
    i_ex_branch_taken = branch;
    i_id_rs           = rs;
    i_id_rt           = rt;
    i_ex_rt           = exRt;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Called at a falling edge: checks the combinational outputs, advances the
  // model across the rising edge and checks the registered outputs after it.
  task automatic stepCycle();
    bit pipeMoves;
    bit loadUse;
    bit accept;
    bit expHalt;
    #1;
    pipeMoves = (mMode == 1) || (mMode == 2);
    loadUse   = i_ex_mem_read && (i_ex_rt != 0) &&
                ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    expHalt   = !(pipeMoves || mMode == 3);
    checkOutput("halt", o_halt, expHalt);
    checkOutput("stall", o_stall, pipeMoves && !i_ex_branch_taken && loadUse);
    checkOutput("pc_write_en", o_pc_write_en, pipeMoves && (i_ex_branch_taken || !loadUse));
    checkOutput("flush_ifid", o_flush_ifid, (pipeMoves && i_ex_branch_taken) || mMode == 3);
    checkOutput("flush_idex", o_flush_idex, pipeMoves && (i_ex_branch_taken || loadUse));
    accept = pipeMoves && i_id_halt && !loadUse && !i_ex_branch_taken;
    @(posedge i_clk);
    if (!expHalt) mCount = mCount + 32'd1;
    case (mMode)
      0: begin
        if (i_dbg_run) mMode = 1;
        else if (i_dbg_step) mMode = 2;
      end
      1, 2: begin
        if (accept) begin
          mMode = 3;
          mDrainLeft = DRAIN;
        end else if (mMode == 2) begin
          mMode = 0;
        end
      end
      3: begin
        mDrainLeft--;
        if (mDrainLeft == 0) mMode = 4;
      end
      default: ;
    endcase
    #1;
    checkOutput("state", o_state, mMode);
    checkOutput("done", o_done, mMode == 4);
    checkOutput("cycle_count", o_cycle_count, mCount);
    @(negedge i_clk);
  endtask

  // Called at a falling edge: asserts reset between edges and expects the
  // effect before any rising edge arrives.
  task automatic resetMidCycle();
    #2 i_reset = 1'b1;
    #1;
    mMode = 0;
    mDrainLeft = 0;
    mCount = 32'd0;
    checkOutput("async_state", o_state, 0);
    checkOutput("async_count", o_cycle_count, 0);
    checkOutput("async_halt", o_halt, 1);
    checkOutput("async_done", o_done, 0);
    checkOutput("async_pc_write_en", o_pc_write_en, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    applyIdle();
    @(negedge i_clk);
    #1;
    checkOutput("reset_state", o_state, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_count", o_cycle_count, 0);
    checkOutput("reset_halt", o_halt, 1);
    checkOutput("reset_stall", o_stall, 0);
    checkOutput("reset_pc_write_en", o_pc_write_en, 0);
    checkOutput("reset_flush_ifid", o_flush_ifid, 0);
    checkOutput("reset_flush_idex", o_flush_idex, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Single step: one advancing cycle, then back to idle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    applyIdle();
    stepCycle();
    checkOutput("step_back_idle", o_state, 0);
    checkOutput("step_count", o_cycle_count, 1);
    stepCycle();
    checkOutput("idle_count_holds", o_cycle_count, 1);

    // Run with run and step together: run wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    checkOutput("run_wins", o_state, 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd7, 5'd5);
    #1;
    checkOutput("lu_stall", o_stall, 1);
    checkOutput("lu_flush_idex", o_flush_idex, 1);
    checkOutput("lu_pc_write_en", o_pc_write_en, 0);
    stepCycle();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("r0_no_stall", o_stall, 0);
    checkOutput("r0_pc_write_en", o_pc_write_en, 1);
    stepCycle();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd5, 5'd5);
    #1;
    checkOutput("br_flush_ifid", o_flush_ifid, 1);
    checkOutput("br_flush_idex", o_flush_idex, 1);
    checkOutput("br_stall", o_stall, 0);
    checkOutput("br_pc_write_en", o_pc_write_en, 1);
    stepCycle();

    // HALT under a taken branch is dropped; under load-use it waits a cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    stepCycle();
    checkOutput("halt_branch_ignored", o_state, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3);
    stepCycle();
    checkOutput("halt_lu_waits", o_state, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);
    stepCycle();
    checkOutput("halt_accepted", o_state, 3);

    applyIdle();
    for (int i = 0; i < DRAIN; i++) begin
      #1;
      checkOutput("drain_pc_write_en", o_pc_write_en, 0);
      checkOutput("drain_state", o_state, 3);
      stepCycle();
    end
    checkOutput("done_state", o_state, 4);
    checkOutput("done_flag", o_done, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    checkOutput("done_ignores_run", o_state, 4);
    applyIdle();
    stepCycle();

    // Asynchronous reset in the middle of a drain.
    resetMidCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    stepCycle();
    applyIdle();
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_drain", o_state, 3);
    resetMidCycle();

    // Randomized traffic; small register range so hazards occur often.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
      if ((mMode == 4 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        resetMidCycle();
      else
        stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
